// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_DIV_RUN,
    S_DIV_FIX,
    S_DONE
  } md_state_e;

endpackage

// File: rtl/ex_div_iter.sv
// Restoring divider: one quotient bit per cycle on operand magnitudes,
// with the sign fix-up applied combinationally to the outputs.
module ex_div_iter #(
  parameter int unsigned DIV_ITERS = muldiv_pkg::DIV_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_signed,
  input  logic        i_run,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_done,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  localparam logic [4:0] LAST = 5'(DIV_ITERS - 1);

  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_qsign;
  logic        r_rsign;

  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  // Operand magnitudes and one trial subtraction of the shifted remainder
  always_comb begin
    w_rs_mag = (i_signed && i_rs[31]) ? -i_rs : i_rs;
    w_rt_mag = (i_signed && i_rt[31]) ? -i_rt : i_rt;
    w_shift  = {r_rem, r_quo[31]};
    w_diff   = w_shift - {1'b0, r_dvs};
  end

  // Load magnitudes/signs on start, then iterate; r_quo shifts the dividend out as quotient bits shift in
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_rs_mag;
      r_dvs   <= w_rt_mag;
      r_qsign <= i_signed & (i_rs[31] ^ i_rt[31]);
      r_rsign <= i_signed & i_rs[31];
    end else if (i_run) begin
      r_cnt <= r_cnt + 5'd1;
      if (!w_diff[32]) begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shift[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

  // Done pulse on the final iteration and sign-corrected results
  always_comb begin
    o_done = i_run && (r_cnt == LAST);
    o_quo  = r_qsign ? -r_quo : r_quo;
    o_rem  = r_rsign ? -r_rem : r_rem;
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO write path.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned DIV_ITERS = muldiv_pkg::DIV_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        ex_adv,
  output logic        busy,
  output logic        valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e r_state, w_next;

  logic               r_mul_signed;
  logic [31:0]        r_rs;
  logic [31:0]        r_rt;
  logic signed [65:0] r_prod;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic               w_accept;
  logic               w_is_div;
  logic signed [32:0] w_a;
  logic signed [32:0] w_b;
  logic signed [65:0] w_prod;
  logic               w_div_done;
  logic [31:0]        w_quo;
  logic [31:0]        w_rem;
  logic               w_unused;

  // Accept decode and 33-bit extended multiply
  always_comb begin
    w_accept = (r_state == S_IDLE) && start && !flush;
    w_is_div = (op == MD_DIV) || (op == MD_DIVU);
    w_a      = {r_mul_signed & r_rs[31], r_rs};
    w_b      = {r_mul_signed & r_rt[31], r_rt};
    w_prod   = w_a * w_b;
    w_unused = ^r_prod[65:64];
  end

  ex_div_iter #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept && w_is_div),
    .i_signed (op == MD_DIV),
    .i_run    (r_state == S_DIV_RUN),
    .i_rs     (rs),
    .i_rt     (rt),
    .o_done   (w_div_done),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = w_is_div ? S_DIV_RUN : S_MUL1;
      S_MUL1:    w_next = S_MUL2;
      S_MUL2:    w_next = S_DONE;
      S_DIV_RUN: if (w_div_done) w_next = S_DIV_FIX;
      S_DIV_FIX: w_next = S_DONE;
      S_DONE:    if (ex_adv) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Stall request and result-valid outputs
  always_comb begin
    busy  = !flush && (((r_state == S_IDLE) && start) ||
                       (r_state == S_MUL1) || (r_state == S_MUL2) ||
                       (r_state == S_DIV_RUN) || (r_state == S_DIV_FIX));
    valid = (r_state == S_DONE);
    hi    = r_hi;
    lo    = r_lo;
  end

  // Operand latch, product register and HI/LO result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mul_signed <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_prod       <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      if (w_accept) begin
        r_mul_signed <= (op == MD_MULT);
        r_rs         <= rs;
        r_rt         <= rt;
      end
      if ((r_state == S_MUL1) && !flush) r_prod <= w_prod;
      if ((r_state == S_MUL2) && !flush) begin
        r_hi <= r_prod[63:32];
        r_lo <= r_prod[31:0];
      end else if ((r_state == S_DIV_FIX) && !flush) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with hand-computed expected results.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        ex_adv;
  logic        busy;
  logic        valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ex_muldiv #(.DIV_ITERS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (start),
    .op     (op),
    .rs     (rs),
    .rt     (rt),
    .ex_adv (ex_adv),
    .busy   (busy),
    .valid  (valid),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue an op with start held, check busy each stall cycle, then the result, then advance
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned nb,
                        input logic [31:0] eh, input logic [31:0] el);
    op = o; rs = a; rt = b; start = 1'b1; ex_adv = 1'b0;
    #1;
    for (int unsigned i = 0; i < nb; i++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " valid_low"}, 32'(valid), 32'd0);
      next_cycle();
    end
    chk({tag, " done_busy"}, 32'(busy), 32'd0);
    chk({tag, " done_valid"}, 32'(valid), 32'd1);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    ex_adv = 1'b1; start = 1'b0;
    next_cycle();
    ex_adv = 1'b0;
    #1;
    chk({tag, " back_idle"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; start = 1'b0; op = 2'b00;
    rs = '0; rt = '0; ex_adv = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    next_cycle();

    run_op("MULT -2*3", 2'b00, 32'hFFFFFFFE, 32'h00000003, 3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("MULTU max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'hFFFFFFFE, 32'h00000001);
    run_op("DIV -7/2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("DIVU F..F9/2", 2'b11, 32'hFFFFFFF9, 32'h00000002, 34, 32'h00000001, 32'h7FFFFFFC);
    run_op("DIV 7/0", 2'b10, 32'h00000007, 32'h00000000, 34, 32'h00000007, 32'hFFFFFFFF);
    run_op("DIV min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000);

    // DIVU by zero, then hold in DONE with start still high
    op = 2'b11; rs = 32'h12345678; rt = 32'h0; start = 1'b1; ex_adv = 1'b0;
    for (int unsigned i = 0; i < 34; i++) next_cycle();
    chk("DIVU x/0 valid", 32'(valid), 32'd1);
    chk("DIVU x/0 hi", hi, 32'h12345678);
    chk("DIVU x/0 lo", lo, 32'hFFFFFFFF);
    for (int unsigned i = 0; i < 5; i++) begin
      next_cycle();
      chk("hold valid", 32'(valid), 32'd1);
      chk("hold busy", 32'(busy), 32'd0);
      chk("hold hi", hi, 32'h12345678);
      chk("hold lo", lo, 32'hFFFFFFFF);
    end
    ex_adv = 1'b1; start = 1'b0;
    next_cycle();
    ex_adv = 1'b0;
    #1;
    chk("hold release valid", 32'(valid), 32'd0);
    chk("hold release busy", 32'(busy), 32'd0);

    // Flush at cycle 10 of a DIV; result registers keep the DIVU x/0 values
    op = 2'b10; rs = 32'h00000064; rt = 32'h00000007; start = 1'b1;
    for (int unsigned i = 0; i < 10; i++) next_cycle();
    chk("pre-flush busy", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush busy", 32'(busy), 32'd0);
    next_cycle();
    flush = 1'b0; start = 1'b0;
    #1;
    chk("post-flush busy", 32'(busy), 32'd0);
    chk("post-flush valid", 32'(valid), 32'd0);
    chk("post-flush hi", hi, 32'h12345678);
    chk("post-flush lo", lo, 32'hFFFFFFFF);
    next_cycle();
    chk("post-flush idle hi", hi, 32'h12345678);
    run_op("MULT 3*4", 2'b00, 32'h00000003, 32'h00000004, 3, 32'h00000000, 32'h0000000C);

    // Flush and start together: flush wins, nothing starts
    op = 2'b00; rs = 32'h5; rt = 32'h5; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush+start busy", 32'(busy), 32'd0);
    next_cycle();
    start = 1'b0; flush = 1'b0;
    for (int unsigned i = 0; i < 4; i++) next_cycle();
    chk("flush+start valid", 32'(valid), 32'd0);
    chk("flush+start lo", lo, 32'h0000000C);

    // Reset mid-divide
    op = 2'b11; rs = 32'h00000100; rt = 32'h00000003; start = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0; start = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    chk("mid-reset busy", 32'(busy), 32'd0);
    chk("mid-reset valid", 32'(valid), 32'd0);
    chk("mid-reset hi", hi, 32'h0);
    chk("mid-reset lo", lo, 32'h0);
    next_cycle();

    run_op("DIVU 256/3", 2'b11, 32'h00000100, 32'h00000003, 34, 32'h00000001, 32'h00000055);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit in the EX stage. It consumes the registered EX-stage `start`, operation and GPR operands and computes MULT/MULTU/DIV/DIVU results for the HI/LO write path. While an operation is in flight it raises `busy`, which the hazard unit uses to deassert the ID_EX, EX_MEM1 and PC write enables. Results are held until the EX stage advances.

## Interface
Parameters:
- `DIV_ITERS`, default 32: restoring-divide iterations, one quotient bit per cycle. Only the value 32 is supported.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `flush`  in  1  EX-stage flush (exception/eret); cancels any operation
- `start`  in  1  EX instruction is a mul/div (registered EX_start)
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `rs`  in  32  forwarded source operand (dividend / multiplicand)
- `rt`  in  32  forwarded source operand (divisor / multiplier)
- `ex_adv`  in  1  EX stage advances this cycle (EX_MEM1 write enable)
- `busy`  out  1  stall request, combinational
- `valid`  out  1  `hi`/`lo` hold the result of the current EX instruction
- `hi`  out  32  product[63:32] or remainder
- `lo`  out  32  product[31:0] or quotient

## Operation
States: IDLE, MUL1, MUL2, DIV_RUN, DIV_FIX, DONE.

- **IDLE**
  - `start & ~flush`: latch `op`, `rs` and `rt`.
  - A MULT/MULTU op goes to MUL1. A DIV/DIVU op goes to DIV_RUN with the counter at 0.
- **MUL1**: operands sign-extended (MULT) or zero-extended (MULTU) to 33 bits; the 66-bit product is registered. Next state MUL2.
- **MUL2**: `{hi,lo}` is loaded from product[63:0]. Next state DONE.
- **DIV_RUN**
  - Entry: the magnitudes of `rs` and `rt` are latched (signed only), along with `qsign = rs[31]^rt[31]` and `rsign = rs[31]`. Unsigned ops force both signs to 0.
  - Each cycle does one restoring step: shift the partial remainder left, pull in the next dividend bit, then trial-subtract the divisor. A non-negative result sets the quotient bit to 1 and keeps the difference.
  - When the counter reaches 31, go to DIV_FIX.
- **DIV_FIX**: `lo` takes the quotient, negated if `qsign`. `hi` takes the remainder, negated if `rsign`. Next state DONE.
- **DONE**
  - `valid=1`.
  - `ex_adv` returns the block to IDLE.
  - Otherwise it stays in DONE and holds the result. A `start` that is still high is not restarted.

Combinational outputs:
- `busy = ~flush & ((state==IDLE & start) | state ∈ {MUL1, MUL2, DIV_RUN, DIV_FIX})`
- `valid = (state==DONE)`

Boundaries:
- **Divide by zero**: no exception; the natural algorithm result is returned. DIVU x/0 gives lo=FFFFFFFF, hi=x. DIV 7/0 gives lo=FFFFFFFF, hi=7.
- **DIV 80000000/FFFFFFFF** gives lo=80000000, hi=0.
- **`flush` in any state**: next state IDLE, no result is written, `busy` drops the same cycle. If `flush` and `start` arrive together, `flush` wins.
- **`rst` low mid-operation**: IDLE on the next edge.

## Timing
Reset values:
- state is IDLE
- `hi`=0, `lo`=0
- `busy`=0, `valid`=0
- divider counter and datapath registers are 0

Latency, with the start cycle counted as cycle 0:
- Multiply: `busy` is high in cycles 0–2; DONE (`valid`=1, `busy`=0) in cycle 3.
- Divide: `busy` is high in cycles 0–33; DONE in cycle 34.

Handshake:
- The EX instruction is frozen while `busy` is high.
- It advances in the first DONE cycle with `ex_adv`=1. The HI/LO write logic samples `hi`/`lo` in that cycle.
- `hi`/`lo` hold their value until the next operation overwrites them.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`
  - state enum
  - constant `DIV_ITERS=32`
- One sub-module, `ex_div_iter`. It owns:
  - the restoring iteration
  - the 5-bit counter
  - the sign fix-up
  - a `div_done` pulse
- The multiply path stays inline in `ex_muldiv`.

## Test plan
- **MULT, signed**: `rs`=FFFFFFFE (-2), `rt`=00000003, MULT → `busy` high for 3 cycles, then `valid` with hi=FFFFFFFF, lo=FFFFFFFA.
- **MULTU, unsigned**: `rs`=`rt`=FFFFFFFF, MULTU → hi=FFFFFFFE, lo=00000001 in cycle 3.
- **DIV, signed**: `rs`=FFFFFFF9 (-7), `rt`=00000002, DIV → `busy` for 34 cycles, then lo=FFFFFFFD, hi=FFFFFFFF. Same operands with DIVU → lo=7FFFFFFC, hi=00000001.
- **Divide by zero**: DIVU 12345678/0 → lo=FFFFFFFF, hi=12345678, no hang.
- **Flush mid-divide**: `flush` at cycle 10 of a DIV → `busy` low that cycle, state IDLE, `hi`/`lo` unchanged. A new MULT 3×4 issued 2 cycles later → lo=0000000C in cycle 3.
- **Held result**: `ex_adv`=0 for 5 cycles in DONE with `start` still high → `valid` stays 1, result stable, no restart. `ex_adv`=1 → IDLE next cycle.
